// File: rtl/retire_unit.sv
// In-order retirement stage: pops the ROB head, writes results into the architectural
// register file, counts retirements and raises a one-cycle flush on excepting entries.
module retire_unit #(
    parameter int XLEN  = 64,
    parameter int NREGS = 32,
    parameter int FLAGW = 13
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [4:0]       commit_arf,
    input  logic [XLEN-1:0]  commit_result,
    input  logic [XLEN-1:0]  commit_pc,
    input  logic [FLAGW-1:0] commit_flags,
    input  logic             commit_valid,
    output logic             can_commit,
    input  logic             hold,
    input  logic             restart,
    input  logic [4:0]       rd_addr_a,
    input  logic [4:0]       rd_addr_b,
    output logic [XLEN-1:0]  rd_data_a,
    output logic [XLEN-1:0]  rd_data_b,
    output logic             flush,
    output logic [XLEN-1:0]  exc_pc,
    output logic [3:0]       exc_cause,
    output logic [XLEN-1:0]  retired_count
);

    typedef enum logic [0:0] {
        ST_RUN = 1'b0,
        ST_EXC = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic              can_q;
    logic              flush_q, flush_d;
    logic [XLEN-1:0]   exc_pc_q, exc_pc_d;
    logic [3:0]        exc_cause_q, exc_cause_d;
    logic [XLEN-1:0]   count_q, count_d;
    logic [XLEN-1:0]   arf_q [NREGS];

    logic              retire_s;
    logic              exc_s;
    logic              wr_en_s;
    logic              flags_unused_s;

    // The bundle arrives one cycle after the pop decision, so only a bundle
    // following a granted can_commit is a real retirement.
    assign retire_s       = commit_valid && can_q;
    assign exc_s          = commit_flags[0];
    assign wr_en_s        = (state_q == ST_RUN) && retire_s && !exc_s &&
                            !commit_flags[12] && (commit_arf != 5'd0);
    assign flags_unused_s = ^commit_flags[11:5];

    assign can_commit    = (state_q == ST_RUN) && !hold && !(retire_s && exc_s);
    assign flush         = flush_q;
    assign exc_pc        = exc_pc_q;
    assign exc_cause     = exc_cause_q;
    assign retired_count = count_q;

    // Next-state and next-output computation for the retirement FSM.
    always_comb begin
        state_d     = state_q;
        flush_d     = 1'b0;
        exc_pc_d    = exc_pc_q;
        exc_cause_d = exc_cause_q;
        count_d     = count_q;
        case (state_q)
            ST_RUN: begin
                if (retire_s && exc_s) begin
                    state_d     = ST_EXC;
                    flush_d     = 1'b1;
                    exc_pc_d    = commit_pc;
                    exc_cause_d = commit_flags[4:1];
                end else if (retire_s) begin
                    count_d = count_q + {{(XLEN-1){1'b0}}, 1'b1};
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_EXC: begin
                if (restart) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_EXC;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // FSM state, pop-grant history and registered status outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_RUN;
            can_q       <= 1'b0;
            flush_q     <= 1'b0;
            exc_pc_q    <= '0;
            exc_cause_q <= 4'd0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            can_q       <= can_commit;
            flush_q     <= flush_d;
            exc_pc_q    <= exc_pc_d;
            exc_cause_q <= exc_cause_d;
            count_q     <= count_d;
        end
    end

    // Architectural register file storage.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                arf_q[i] <= '0;
            end
        end else if (wr_en_s) begin
            arf_q[commit_arf] <= commit_result;
        end else begin
            arf_q[0] <= '0;
        end
    end

    // Read port A with same-cycle bypass of the retiring result.
    always_comb begin
        if (rd_addr_a == 5'd0) begin
            rd_data_a = '0;
        end else if (wr_en_s && (rd_addr_a == commit_arf)) begin
            rd_data_a = commit_result;
        end else begin
            rd_data_a = arf_q[rd_addr_a];
        end
    end

    // Read port B with same-cycle bypass of the retiring result.
    always_comb begin
        if (rd_addr_b == 5'd0) begin
            rd_data_b = '0;
        end else if (wr_en_s && (rd_addr_b == commit_arf)) begin
            rd_data_b = commit_result;
        end else begin
            rd_data_b = arf_q[rd_addr_b];
        end
    end

endmodule

// File: tb/tb_retire_unit.sv
// Directed bench for retire_unit: handshake timing, ARF writes/bypass, exceptions, reset.
module tb_retire_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic [4:0]  commit_arf;
    logic [63:0] commit_result;
    logic [63:0] commit_pc;
    logic [12:0] commit_flags;
    logic        commit_valid;
    logic        can_commit;
    logic        hold;
    logic        restart;
    logic [4:0]  rd_addr_a;
    logic [4:0]  rd_addr_b;
    logic [63:0] rd_data_a;
    logic [63:0] rd_data_b;
    logic        flush;
    logic [63:0] exc_pc;
    logic [3:0]  exc_cause;
    logic [63:0] retired_count;

    int checks = 0;
    int errors = 0;

    retire_unit dut (
        .clock         (clock),
        .reset         (reset),
        .commit_arf    (commit_arf),
        .commit_result (commit_result),
        .commit_pc     (commit_pc),
        .commit_flags  (commit_flags),
        .commit_valid  (commit_valid),
        .can_commit    (can_commit),
        .hold          (hold),
        .restart       (restart),
        .rd_addr_a     (rd_addr_a),
        .rd_addr_b     (rd_addr_b),
        .rd_data_a     (rd_data_a),
        .rd_data_b     (rd_data_b),
        .flush         (flush),
        .exc_pc        (exc_pc),
        .exc_cause     (exc_cause),
        .retired_count (retired_count)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic present(input logic v, input logic [4:0] arf, input logic [63:0] res,
                           input logic [63:0] pc, input logic [12:0] flg);
        commit_valid  = v;
        commit_arf    = arf;
        commit_result = res;
        commit_pc     = pc;
        commit_flags  = flg;
    endtask

    task automatic edge_then_settle();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        hold = 1'b0;
        restart = 1'b0;
        rd_addr_a = 5'd0;
        rd_addr_b = 5'd0;
        present(1'b0, 5'd0, 64'h0, 64'h0, 13'h0);
        #12;
        chk("rst_count", retired_count, 64'd0);
        chk("rst_flush", {63'd0, flush}, 64'd0);
        chk("rst_exc_pc", exc_pc, 64'd0);
        chk("rst_exc_cause", {60'd0, exc_cause}, 64'd0);

        // A: first cycle out of reset, nothing presented
        @(negedge clock); reset = 1'b0; #1;
        chk("A_can", {63'd0, can_commit}, 64'd1);
        edge_then_settle();

        // B, C: back-to-back retirements
        @(negedge clock); present(1'b1, 5'd3, 64'h11, 64'h100, 13'h0); rd_addr_a = 5'd3; #1;
        chk("B_can", {63'd0, can_commit}, 64'd1);
        chk("B_bypass", rd_data_a, 64'h11);
        edge_then_settle();
        chk("B_count", retired_count, 64'd1);
        @(negedge clock); present(1'b1, 5'd5, 64'h22, 64'h104, 13'h0); #1;
        chk("C_can", {63'd0, can_commit}, 64'd1);
        edge_then_settle();
        chk("C_count", retired_count, 64'd2);

        // D: hold drops can_commit, but the already-popped entry still retires
        @(negedge clock); hold = 1'b1; present(1'b1, 5'd8, 64'h88, 64'h108, 13'h0);
        rd_addr_a = 5'd3; rd_addr_b = 5'd5; #1;
        chk("D_can", {63'd0, can_commit}, 64'd0);
        chk("D_arf3", rd_data_a, 64'h11);
        chk("D_arf5", rd_data_b, 64'h22);
        edge_then_settle();
        chk("D_count", retired_count, 64'd3);

        // E: stale preview (can_q low) is ignored
        @(negedge clock); hold = 1'b0; present(1'b1, 5'd7, 64'h99, 64'h10c, 13'h0);
        rd_addr_a = 5'd7; rd_addr_b = 5'd8; #1;
        chk("E_can", {63'd0, can_commit}, 64'd1);
        chk("E_no_bypass7", rd_data_a, 64'h0);
        chk("E_arf8", rd_data_b, 64'h88);
        edge_then_settle();
        chk("E_count", retired_count, 64'd3);

        // F: write to r0 is dropped; G: no-writeback flag suppresses write
        @(negedge clock); present(1'b1, 5'd0, 64'hff, 64'h110, 13'h0); rd_addr_a = 5'd0; #1;
        chk("F_r0", rd_data_a, 64'h0);
        edge_then_settle();
        chk("F_count", retired_count, 64'd4);
        @(negedge clock); present(1'b1, 5'd4, 64'h44, 64'h114, 13'h1000); rd_addr_b = 5'd4; #1;
        chk("G_nowb_bypass", rd_data_b, 64'h0);
        edge_then_settle();
        chk("G_count", retired_count, 64'd5);

        // H: confirm stored contents
        @(negedge clock); present(1'b0, 5'd0, 64'h0, 64'h0, 13'h0);
        rd_addr_a = 5'd7; rd_addr_b = 5'd4; #1;
        chk("H_arf7", rd_data_a, 64'h0);
        chk("H_arf4", rd_data_b, 64'h0);
        rd_addr_a = 5'd0; #1;
        chk("H_arf0", rd_data_a, 64'h0);
        edge_then_settle();

        // I: exception retirement
        @(negedge clock); present(1'b1, 5'd6, 64'h66, 64'h1000, 13'h007); rd_addr_b = 5'd6; #1;
        chk("I_can", {63'd0, can_commit}, 64'd0);
        chk("I_no_bypass", rd_data_b, 64'h0);
        edge_then_settle();
        chk("I_flush", {63'd0, flush}, 64'd1);
        chk("I_exc_pc", exc_pc, 64'h1000);
        chk("I_cause", {60'd0, exc_cause}, 64'd3);
        chk("I_count", retired_count, 64'd5);

        // J: in EXC, flush lasts one cycle
        @(negedge clock); present(1'b0, 5'd0, 64'h0, 64'h0, 13'h0); #1;
        chk("J_can", {63'd0, can_commit}, 64'd0);
        chk("J_arf6", rd_data_b, 64'h0);
        edge_then_settle();
        chk("J_flush", {63'd0, flush}, 64'd0);
        chk("J_exc_pc", exc_pc, 64'h1000);

        // K: restart pulse
        @(negedge clock); restart = 1'b1; #1;
        chk("K_can", {63'd0, can_commit}, 64'd0);
        edge_then_settle();
        chk("K_cause", {60'd0, exc_cause}, 64'd3);

        // L: first RUN cycle; restart while in RUN is harmless
        @(negedge clock); restart = 1'b1; #1;
        chk("L_can", {63'd0, can_commit}, 64'd1);
        edge_then_settle();

        // M: bypass while retiring into r9
        @(negedge clock); restart = 1'b0; present(1'b1, 5'd9, 64'habcd, 64'h1004, 13'h0);
        rd_addr_a = 5'd9; rd_addr_b = 5'd3; #1;
        chk("M_can", {63'd0, can_commit}, 64'd1);
        chk("M_bypass", rd_data_a, 64'habcd);
        edge_then_settle();
        chk("M_count", retired_count, 64'd6);

        // N: stored value after the bypass cycle
        @(negedge clock); present(1'b0, 5'd0, 64'h0, 64'h0, 13'h0); #1;
        chk("N_arf9", rd_data_a, 64'habcd);
        chk("N_arf3", rd_data_b, 64'h11);
        edge_then_settle();

        // O: second exception, then asynchronous reset mid-EXC
        @(negedge clock); present(1'b1, 5'd3, 64'h33, 64'h2000, 13'h005); #1;
        chk("O_can", {63'd0, can_commit}, 64'd0);
        edge_then_settle();
        chk("O_flush", {63'd0, flush}, 64'd1);
        chk("O_exc_pc", exc_pc, 64'h2000);
        chk("O_cause", {60'd0, exc_cause}, 64'd2);
        present(1'b0, 5'd0, 64'h0, 64'h0, 13'h0); rd_addr_b = 5'd3; #1;
        chk("O_arf3_kept", rd_data_b, 64'h11);
        chk("O_count", retired_count, 64'd6);
        reset = 1'b1; #1;
        chk("R_flush", {63'd0, flush}, 64'd0);
        chk("R_exc_pc", exc_pc, 64'h0);
        chk("R_cause", {60'd0, exc_cause}, 64'd0);
        chk("R_count", retired_count, 64'd0);
        chk("R_arf3", rd_data_b, 64'h0);
        @(negedge clock); reset = 1'b0; #1;
        chk("R_can", {63'd0, can_commit}, 64'd1);
        edge_then_settle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/retire_unit.md
Name: retire_unit

Overview:
- In-order retirement stage on the commit side of the reorder buffer.
- Drives the ROB's can_commit handshake, consumes the registered commit bundle, and writes retired results into the architectural register file (ARF).
- Detects excepting entries, halts retirement, signals a one-cycle flush with the faulting PC, and waits for a restart from the front end.
- Provides two ARF read ports and a retired-instruction counter.

Parameters:
- XLEN, 64, data and PC width.
- NREGS, 32, number of architectural registers (index width 5).
- FLAGW, 13, width of commit_flags.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- commit_arf  in  5  destination register of the presented entry.
- commit_result  in  XLEN  result of the presented entry.
- commit_pc  in  XLEN  PC of the presented entry.
- commit_flags  in  FLAGW  [0] exception, [4:1] cause, [12] no-writeback; other bits ignored.
- commit_valid  in  1  presented entry is complete.
- can_commit  out  1  permit the ROB to pop its head at the next edge.
- hold  in  1  debug/stall request; suppresses can_commit.
- restart  in  1  one-cycle pulse; leave EXC.
- rd_addr_a, rd_addr_b  in  5 each  ARF read addresses.
- rd_data_a, rd_data_b  out  XLEN each  ARF read data, combinational.
- flush  out  1  one-cycle pulse on exception retirement.
- exc_pc  out  XLEN  PC of the faulting entry.
- exc_cause  out  4  cause of the faulting entry.
- retired_count  out  XLEN  count of non-excepting retirements.

Behaviour:
- Commit-bundle timing is fixed by the ROB: the bundle is registered one cycle after the pop decision.
  - Internal register can_q <= can_commit every cycle; reset value 0.
  - A cycle "retires" iff retire = commit_valid && can_q.
  - If commit_valid is high while can_q is 0, the bundle is a stale preview and must be ignored: no write, no count.
- States: RUN, EXC. Reset enters RUN.
- can_commit = (state==RUN) && !hold && !(retire && commit_flags[0]).
  - This is a combinational path, so the ROB cannot pop the next entry at the edge ending an exception retirement.
- Normal retire (RUN, retire, flags[0]=0):
  - ARF[commit_arf] <= commit_result at the edge, unless flags[12]=1 or commit_arf==0.
  - retired_count increments by 1, wrapping modulo 2^XLEN.
- Exception retire (RUN, retire, flags[0]=1):
  - No ARF write; no count increment.
  - exc_pc <= commit_pc and exc_cause <= flags[4:1].
  - flush=1 for exactly the next cycle; state -> EXC.
- EXC:
  - can_commit=0; any retire seen is ignored. None is possible, because can_q is 0.
  - exc_pc and exc_cause hold their values.
  - restart=1 -> RUN at the next edge. can_commit may rise in the first RUN cycle.
  - restart in RUN has no effect.
- ARF:
  - 32 x XLEN entries; register 0 always reads 0.
  - Reads are combinational.
  - Same-cycle bypass: if a read address equals the register being written this cycle (valid write, address nonzero), return commit_result.
- hold: deasserting can_commit stops pops from the next edge. The entry already popped, if any, still retires in the current cycle.
- Reset (async, any time, including mid-EXC):
  - state=RUN, can_q=0, flush=0, exc_pc=0, exc_cause=0, retired_count=0, all ARF entries 0.
  - can_commit=1 once reset deasserts, provided hold=0.
- Back-to-back: one retirement per cycle at full throughput while commit_valid stays high and can_commit stays high.

Test Plan:
- Reset, then present valid entries arf=3 result=0x11 and arf=5 result=0x22 on consecutive cycles with can_q high -> ARF[3]=0x11, ARF[5]=0x22, retired_count=2, can_commit stays 1.
- commit_valid=1 with can_q=0 (previous cycle hold=1), arf=7 result=0x99 -> ARF[7] unchanged, count unchanged.
- Retire entry with arf=0 result=0xFF, then entry with flags[12]=1 and arf=4 -> rd_data for 0 and 4 both return 0; count increases by 2.
- Retire entry pc=0x1000 flags=0x007 (exception, cause 3) -> can_commit=0 in the same cycle; flush=1 for one cycle; exc_pc=0x1000; exc_cause=3; no ARF write; count unchanged. Then pulse restart -> state RUN, can_commit=1 the next cycle.
- Read rd_addr_a=9 while retiring arf=9 result=0xABCD -> rd_data_a=0xABCD in the same cycle; the array holds 0xABCD afterwards.
- Assert reset asynchronously while in EXC with retired_count=5 -> immediately state RUN, flush=0, exc_pc=0, retired_count=0, ARF[3]=0.
